// File: rtl/x_serial_tx.sv
// x_serial_tx: parallel-to-serial feeder for the bit-serial x port of a MAC PE.
// Streams nbits of a word MSB-first over a 4-phase dual-rail link (xr / xd / xa).
module x_serial_tx #(
   parameter int NOC_WID           = 16,
   parameter int REGIONAL_ADDR_WID = 11,
   parameter int SYNC_STAGES       = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NOC_WID-1:0]           cfg_dat,
   input  logic [REGIONAL_ADDR_WID-1:0] cfg_adr,
   input  logic [REGIONAL_ADDR_WID-1:0] slv_addr,
   input  logic [NOC_WID-1:0]           in_dat,
   input  logic                         in_vld,
   output logic                         in_rdy,
   output logic                         busy,
   output logic                         done,
   output logic                         xr,
   output logic [1:0]                   xd,
   input  logic                         xa
);
   localparam int CNT_W = $clog2(NOC_WID + 1);
   localparam logic [CNT_W-1:0]   MAX_BITS = CNT_W'(NOC_WID);
   localparam logic [NOC_WID-1:0] MAX_DAT  = NOC_WID'(NOC_WID);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_DATA, S_NULL, S_REL} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     nbits_cfg;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NOC_WID-1:0]   sh_q, sh_d;
   logic                 xr_q, xr_d;
   logic [1:0]           xd_q, xd_d;
   logic                 done_q, done_d;
   logic                 in_rdy_q, busy_q;
   logic [SYNC_STAGES-1:0] xa_sync;
   logic                 xa_s;

   assign xa_s   = xa_sync[SYNC_STAGES-1];
   assign in_rdy = in_rdy_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign xr     = xr_q;
   assign xd     = xd_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         xa_sync <= '0;
      end else begin
         xa_sync[0] <= xa;
         for (int i = 1; i < SYNC_STAGES; i++) xa_sync[i] <= xa_sync[i-1];
      end
   end

   // Oversized lengths saturate so a frame never exceeds the word width.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nbits_cfg <= '0;
      end else if (cfg_adr == slv_addr) begin
         nbits_cfg <= (cfg_dat > MAX_DAT) ? MAX_BITS : cfg_dat[CNT_W-1:0];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      xr_d    = xr_q;
      xd_d    = xd_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_vld && in_rdy_q) begin
               // Left-align the frame so the next bit to send is always the MSB.
               sh_d    = in_dat << (MAX_BITS - nbits_cfg);
               cnt_d   = nbits_cfg;
               xr_d    = 1'b1;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (xa_s) begin
               if (cnt_q == '0) begin
                  xr_d    = 1'b0;
                  state_d = S_REL;
               end else begin
                  xd_d    = sh_q[NOC_WID-1] ? 2'b10 : 2'b01;
                  sh_d    = sh_q << 1;
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (!xa_s) begin
               xd_d    = 2'b00;
               cnt_d   = cnt_q - CNT_ONE;
               state_d = S_NULL;
            end
         end
         S_NULL: begin
            if (xa_s) begin
               if (cnt_q != '0) begin
                  xd_d    = sh_q[NOC_WID-1] ? 2'b10 : 2'b01;
                  sh_d    = sh_q << 1;
                  state_d = S_DATA;
               end else begin
                  xr_d    = 1'b0;
                  state_d = S_REL;
               end
            end
         end
         S_REL: begin
            if (!xa_s) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         sh_q     <= '0;
         xr_q     <= 1'b0;
         xd_q     <= 2'b00;
         done_q   <= 1'b0;
         in_rdy_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
         xr_q     <= xr_d;
         xd_q     <= xd_d;
         done_q   <= done_d;
         in_rdy_q <= (state_d == S_IDLE);
         busy_q   <= (state_d != S_IDLE);
      end
   end

endmodule

// File: tb/tb_x_serial_tx.sv
// Bench for x_serial_tx: a behavioural dual-rail receiver rebuilds each frame and a
// scoreboard compares it with the masked word expected at accept time.
module tb_x_serial_tx;
   localparam int W  = 16;
   localparam int AW = 11;
   localparam logic [AW-1:0] SLV  = 11'h040;
   localparam logic [AW-1:0] IDLE_ADR = 11'h7ff;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  cfg_dat = '0;
   logic [AW-1:0] cfg_adr = IDLE_ADR;
   logic [AW-1:0] slv_addr = SLV;
   logic [W-1:0]  in_dat = '0;
   logic          in_vld = 1'b0;
   logic          in_rdy, busy, done, xr, xa;
   logic [1:0]    xd;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int nb_model = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   int           exp_n_q[$];
   int           got_n_q[$];

   x_serial_tx #(.NOC_WID(W), .REGIONAL_ADDR_WID(AW), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .cfg_dat(cfg_dat), .cfg_adr(cfg_adr), .slv_addr(slv_addr),
      .in_dat(in_dat), .in_vld(in_vld), .in_rdy(in_rdy), .busy(busy), .done(done),
      .xr(xr), .xd(xd), .xa(xa)
   );

   // clock / reset
   always #5 clk = ~clk;

   // receiver: acknowledges request, each data word and each null, then the release
   typedef enum int {R_IDLE, R_WAIT, R_DATA} rx_t;
   rx_t          rx_st = R_IDLE;
   int           rx_dly = 0;
   int           rx_n = 0;
   logic [W-1:0] rx_word = '0;
   initial xa = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         rx_st = R_IDLE; xa = 1'b0; rx_dly = 0;
      end else if (rx_dly > 0) begin
         rx_dly--;
      end else begin
         case (rx_st)
            R_IDLE: if (xr === 1'b1) begin
               xa = 1'b1; rx_word = '0; rx_n = 0; rx_st = R_WAIT;
               rx_dly = $urandom_range(0, 3);
            end
            R_WAIT: if (xd === 2'b10 || xd === 2'b01) begin
               rx_word = {rx_word[W-2:0], xd[1]}; rx_n++;
               xa = 1'b0; rx_st = R_DATA; rx_dly = $urandom_range(0, 3);
            end else if (xr === 1'b0) begin
               got_q.push_back(rx_word); got_n_q.push_back(rx_n);
               xa = 1'b0; rx_st = R_IDLE; rx_dly = $urandom_range(0, 3);
            end
            R_DATA: if (xd === 2'b00) begin
               xa = 1'b1; rx_st = R_WAIT; rx_dly = $urandom_range(0, 3);
            end
            default: rx_st = R_IDLE;
         endcase
      end
   end

   // protocol monitor
   int         mon_err = 0;
   int         done_cnt = 0;
   logic [1:0] xd_prev = 2'b00;
   always @(negedge clk) begin
      if (xd === 2'b11) mon_err++;
      if (xd !== 2'b00 && xr !== 1'b1) mon_err++;
      if (xd_prev != 2'b00 && xd != 2'b00 && xd != xd_prev) mon_err++;
      if (xr === 1'b1 && busy !== 1'b1) mon_err++;
      if (busy === 1'b1 && in_rdy === 1'b1) mon_err++;
      if (done === 1'b1) done_cnt++;
      xd_prev = xd;
   end

   function automatic logic [W-1:0] mask_of(input int nb);
      logic [W-1:0] m;
      m = '0;
      for (int i = 0; i < nb; i++) m[i] = 1'b1;
      return m;
   endfunction

   // driver tasks
   task automatic write_cfg(input logic [AW-1:0] adr, input logic [W-1:0] v);
      @(negedge clk); cfg_adr = adr; cfg_dat = v;
      @(negedge clk); cfg_adr = IDLE_ADR; cfg_dat = '0;
      if (adr == SLV) nb_model = (v > W) ? W : int'(v);
   endtask

   task automatic send_word(input logic [W-1:0] d, output bit ok);
      ok = 1'b0;
      @(negedge clk); in_dat = d; in_vld = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (in_rdy === 1'b1) begin
            exp_q.push_back(d & mask_of(nb_model)); exp_n_q.push_back(nb_model);
            ok = 1'b1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      in_vld = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   // scoreboard pop; the comparisons stay in each test
   task automatic pop_frame(output logic [W-1:0] got, output logic [W-1:0] expv,
                            output int got_n, output int exp_n);
      got   = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      got_n = (got_n_q.size() > 0) ? got_n_q.pop_front() : -1;
      expv  = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      exp_n = (exp_n_q.size() > 0) ? exp_n_q.pop_front() : 0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      chk_cnt++; if (xr !== 1'b0) $display("FAIL reset_xr got=%b exp=0", xr); else pass_cnt++;
      chk_cnt++; if (xd !== 2'b00) $display("FAIL reset_xd got=%b exp=00", xd); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); else pass_cnt++;
      chk_cnt++; if (in_rdy !== 1'b0) $display("FAIL reset_in_rdy_held got=%b exp=0", in_rdy); else pass_cnt++;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_cnt++; if (in_rdy !== 1'b1) $display("FAIL reset_in_rdy_after got=%b exp=1", in_rdy); else pass_cnt++;
   endtask

   task automatic test_nbits_zero();
      bit ok; logic [W-1:0] g, e; int gn, en, d0;
      d0 = done_cnt;
      send_word(16'hffff, ok);
      wait_done(ok);
      chk_cnt++; if (!ok) $display("FAIL zero_done_timeout got=0 exp=1"); else pass_cnt++;
      @(negedge clk);
      chk_cnt++; if (done !== 1'b0) $display("FAIL zero_done_pulse got=%b exp=0", done); else pass_cnt++;
      repeat (2) @(negedge clk);
      chk_cnt++; if (done_cnt - d0 != 1) $display("FAIL zero_done_count got=%0d exp=1", done_cnt - d0); else pass_cnt++;
      pop_frame(g, e, gn, en);
      chk_cnt++; if (g !== e) $display("FAIL zero_x got=%h exp=%h", g, e); else pass_cnt++;
      chk_cnt++; if (gn != en) $display("FAIL zero_bits got=%0d exp=%0d", gn, en); else pass_cnt++;
   endtask

   task automatic test_basic4();
      bit ok; logic [W-1:0] g, e; int gn, en;
      write_cfg(SLV, 16'd4);
      send_word(16'h000b, ok);
      chk_cnt++; if (xr !== 1'b1) $display("FAIL b4_xr_rise got=%b exp=1", xr); else pass_cnt++;
      wait_done(ok);
      chk_cnt++; if (!ok) $display("FAIL b4_done_timeout got=0 exp=1"); else pass_cnt++;
      chk_cnt++; if (xr !== 1'b0 || in_rdy !== 1'b1) $display("FAIL b4_idle got xr=%b in_rdy=%b exp xr=0 in_rdy=1", xr, in_rdy); else pass_cnt++;
      pop_frame(g, e, gn, en);
      chk_cnt++; if (g !== e) $display("FAIL b4_x got=%h exp=%h", g, e); else pass_cnt++;
      chk_cnt++; if (gn != en) $display("FAIL b4_bits got=%0d exp=%0d", gn, en); else pass_cnt++;
   endtask

   task automatic test_full16();
      bit ok; logic [W-1:0] g, e; int gn, en;
      logic [W-1:0] words[3];
      words[0] = 16'ha5c3;
      words[1] = W'($urandom_range(0, 65535));
      words[2] = W'($urandom_range(0, 65535));
      write_cfg(SLV, 16'd16);
      for (int k = 0; k < 3; k++) begin
         send_word(words[k], ok);
         wait_done(ok);
         chk_cnt++; if (!ok) $display("FAIL f16_done_timeout[%0d] got=0 exp=1", k); else pass_cnt++;
         pop_frame(g, e, gn, en);
         chk_cnt++; if (g !== e || gn != en) $display("FAIL f16_x[%0d] got=%h/%0d exp=%h/%0d", k, g, gn, e, en); else pass_cnt++;
      end
   endtask

   task automatic test_cfg_snapshot();
      bit ok; logic [W-1:0] g, e; int gn, en;
      write_cfg(SLV, 16'd4);
      send_word(16'h000d, ok);
      write_cfg(SLV, 16'd3);
      wait_done(ok);
      pop_frame(g, e, gn, en);
      chk_cnt++; if (g !== e || gn != en) $display("FAIL snap_old got=%h/%0d exp=%h/%0d", g, gn, e, en); else pass_cnt++;
      send_word(16'h0007, ok);
      wait_done(ok);
      pop_frame(g, e, gn, en);
      chk_cnt++; if (g !== e || gn != en) $display("FAIL snap_new got=%h/%0d exp=%h/%0d", g, gn, e, en); else pass_cnt++;
   endtask

   task automatic test_clamp_and_hold();
      bit ok; logic [W-1:0] g, e; int gn, en;
      write_cfg(SLV, 16'd20);
      write_cfg(SLV + 11'd1, 16'd2);
      send_word(16'h3c96, ok);
      in_dat = 16'h5a0f; in_vld = 1'b1;
      @(negedge clk);
      chk_cnt++; if (in_rdy !== 1'b0) $display("FAIL hold_in_rdy got=%b exp=0", in_rdy); else pass_cnt++;
      wait_done(ok);
      chk_cnt++; if (in_rdy !== 1'b1) $display("FAIL hold_rdy_at_done got=%b exp=1", in_rdy); else pass_cnt++;
      exp_q.push_back(16'h5a0f & mask_of(nb_model)); exp_n_q.push_back(nb_model);
      @(negedge clk); in_vld = 1'b0;
      chk_cnt++; if (busy !== 1'b1) $display("FAIL hold_taken_after_done got=%b exp=1", busy); else pass_cnt++;
      pop_frame(g, e, gn, en);
      chk_cnt++; if (g !== e || gn != en) $display("FAIL clamp_x got=%h/%0d exp=%h/%0d", g, gn, e, en); else pass_cnt++;
      wait_done(ok);
      pop_frame(g, e, gn, en);
      chk_cnt++; if (g !== e || gn != en) $display("FAIL hold_x got=%h/%0d exp=%h/%0d", g, gn, e, en); else pass_cnt++;
   endtask

   task automatic test_reset_mid_frame();
      bit ok, seen; logic [W-1:0] g, e; int gn, en;
      write_cfg(SLV, 16'd16);
      send_word(16'hffff, ok);
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (xd !== 2'b00) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      chk_cnt++; if (!seen) $display("FAIL rstmid_data_timeout got=0 exp=1"); else pass_cnt++;
      #2 rst = 1'b0;
      #1;
      chk_cnt++; if (xr !== 1'b0 || xd !== 2'b00) $display("FAIL rstmid_async got xr=%b xd=%b exp xr=0 xd=00", xr, xd); else pass_cnt++;
      exp_q.delete(); exp_n_q.delete(); got_q.delete(); got_n_q.delete();
      nb_model = 0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_cnt++; if (in_rdy !== 1'b1 || busy !== 1'b0) $display("FAIL rstmid_recover got rdy=%b busy=%b exp rdy=1 busy=0", in_rdy, busy); else pass_cnt++;
      write_cfg(SLV, 16'd5);
      send_word(16'h0035, ok);
      wait_done(ok);
      pop_frame(g, e, gn, en);
      chk_cnt++; if (g !== e || gn != en) $display("FAIL rstmid_next got=%h/%0d exp=%h/%0d", g, gn, e, en); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_nbits_zero();
      test_basic4();
      test_full16();
      test_cfg_snapshot();
      test_clamp_and_hold();
      test_reset_mid_frame();
      repeat (3) @(negedge clk);
      chk_cnt++; if (mon_err != 0) $display("FAIL protocol_monitor got=%0d exp=0", mon_err); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
